bcd_to_bin: RTL and testbench

//  Sequential BCD-to-binary converter (reverse double-dabble): the input-side

---
 rtl/bcd_to_bin.sv | 164 ++++++++++++++++
 tb/tb_bcd_to_bin.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin.sv
// bcd_to_bin: sequential BCD-to-binary converter (reverse double-dabble).
// Turns DIGITS packed BCD digits into a BIN_W-bit binary operand, one bit
// per clock, behind a start/busy/done handshake. Latency is 4*DIGITS cycles.
// Optional feature macro: BCD2BIN_SIGN_EN adds neg_in and returns the two's
// complement of the magnitude when neg_in is set at start.
module bcd_to_bin #(
  parameter int unsigned DIGITS = 6,
  parameter int unsigned BIN_W  = 20
) (
  input  logic                  CLK,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
`ifdef BCD2BIN_SIGN_EN
  input  logic                  neg_in,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [BIN_W-1:0]      bin_out
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned SR_W  = 2 * BCD_W;
  localparam int unsigned CNT_W = $clog2(BCD_W + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [SR_W-1:0]    sr_q, sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
`ifdef BCD2BIN_SIGN_EN
  logic               neg_q, neg_d;
`endif

  logic               digit_bad_c;
  logic [SR_W-1:0]    sr_step_c;
  logic [BIN_W-1:0]   mag_c;
  logic [BIN_W-1:0]   res_c;

  // Flag any input digit above 9.
  always_comb begin
    digit_bad_c = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) begin
        digit_bad_c = 1'b1;
      end
    end
  end

  // One conversion step: shift right, then pull each BCD nibble >= 8 down by 3.
  always_comb begin
    logic [3:0] nib;
    sr_step_c = sr_q >> 1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      nib = sr_step_c[BCD_W + 4*i +: 4];
      if (nib >= 4'd8) begin
        sr_step_c[BCD_W + 4*i +: 4] = nib - 4'd3;
      end
    end
  end

  // Final result taken from the accumulator half after the last step.
  always_comb begin
    mag_c = BIN_W'(sr_step_c[BCD_W-1:0]);
`ifdef BCD2BIN_SIGN_EN
    res_c = neg_q ? (BIN_W'(0) - mag_c) : mag_c;
`else
    res_c = mag_c;
`endif
  end

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    bin_d   = bin_q;
`ifdef BCD2BIN_SIGN_EN
    neg_d   = neg_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (digit_bad_c) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            err_d   = 1'b1;
            bin_d   = '0;
          end else begin
            state_d = S_CONV;
            sr_d    = {bcd_in, {BCD_W{1'b0}}};
            cnt_d   = CNT_W'(BCD_W);
            busy_d  = 1'b1;
            err_d   = 1'b0;
`ifdef BCD2BIN_SIGN_EN
            neg_d   = neg_in;
`endif
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CONV: begin
        sr_d  = sr_step_c;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          bin_d   = res_c;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      bin_q   <= '0;
`ifdef BCD2BIN_SIGN_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      bin_q   <= bin_d;
`ifdef BCD2BIN_SIGN_EN
      neg_q   <= neg_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign bin_out = bin_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// tb_bcd_to_bin: directed and randomized checks of bcd_to_bin against a
// decimal-arithmetic reference model. Build with +define+BCD2BIN_SIGN_EN
// to cover the signed variant.
module tb_bcd_to_bin;

  localparam int unsigned DIGITS = 6;
  localparam int unsigned BIN_W  = 20;
  localparam int unsigned BCD_W  = 4 * DIGITS;
`ifdef BCD2BIN_SIGN_EN
  localparam bit SIGN_EN = 1'b1;
`else
  localparam bit SIGN_EN = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              reset_n;
  logic              start = 1'b0;
  logic [BCD_W-1:0]  bcd_in = '0;
  logic              neg_in = 1'b0;
  logic              busy;
  logic              done;
  logic              err;
  logic [BIN_W-1:0]  bin_out;

  bcd_to_bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .CLK     (CLK),
    .reset_n (reset_n),
    .start   (start),
    .bcd_in  (bcd_in),
`ifdef BCD2BIN_SIGN_EN
    .neg_in  (neg_in),
`endif
    .busy    (busy),
    .done    (done),
    .err     (err),
    .bin_out (bin_out)
  );

  always #5 CLK = ~CLK;

  int checks    = 0;
  int failures  = 0;
  int done_cnt  = 0;
  bit run_chk   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: any digit above 9 is an error.
  function automatic bit ref_bad(input logic [BCD_W-1:0] b);
    logic [3:0] d;
    ref_bad = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      d = b[4*i +: 4];
      if (d > 4'd9) ref_bad = 1'b1;
    end
  endfunction

  // Reference: decimal value of the digits, optionally negated, modulo 2^BIN_W.
  function automatic logic [BIN_W-1:0] ref_val(input logic [BCD_W-1:0] b, input bit n);
    int unsigned v;
    logic [3:0]  d;
    v = 0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      d = b[4*i +: 4];
      v = v * 10 + int'(d);
    end
    ref_val = BIN_W'(v);
    if (n) ref_val = BIN_W'(0) - ref_val;
  endfunction

  function automatic logic [BCD_W-1:0] rand_bcd();
    logic [BCD_W-1:0] r;
    int               pos;
    for (int i = 0; i < int'(DIGITS); i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    if ($urandom_range(0, 7) == 0) begin
      pos = int'($urandom_range(0, DIGITS - 1));
      r[4*pos +: 4] = 4'($urandom_range(10, 15));
    end
    return r;
  endfunction

  // Behavioural model: a countdown to a precomputed decimal result.
  bit               m_busy = 1'b0;
  bit               m_done = 1'b0;
  bit               m_err  = 1'b0;
  logic [BIN_W-1:0] m_bin  = '0;
  logic [BIN_W-1:0] m_res  = '0;
  int               m_rem  = 0;

  always @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_err  <= 1'b0;
      m_bin  <= '0;
      m_rem  <= 0;
    end else if (m_busy) begin
      m_done <= 1'b0;
      m_rem  <= m_rem - 1;
      if (m_rem == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_bin  <= m_res;
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        if (ref_bad(bcd_in)) begin
          m_done <= 1'b1;
          m_err  <= 1'b1;
          m_bin  <= '0;
        end else begin
          m_busy <= 1'b1;
          m_err  <= 1'b0;
          m_rem  <= int'(BCD_W);
          m_res  <= ref_val(bcd_in, SIGN_EN && neg_in);
        end
      end
    end
  end

  // Cycle-by-cycle compare against the model, away from the active edge.
  always @(negedge CLK) begin
    if (run_chk) begin
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      check("err", 32'(err), 32'(m_err));
      check("bin_out", 32'(bin_out), 32'(m_bin));
      if (done === 1'b1) done_cnt++;
    end
  end

  // Issue one request and wait (bounded) for done; optional ignored extra starts.
  task automatic run_conv(input logic [BCD_W-1:0] b, input bit n, input bit extra,
                          output int lat, output int nbusy);
    bcd_in = b;
    neg_in = n;
    start  = 1'b1;
    @(posedge CLK);
    #2;
    start = 1'b0;
    lat   = 0;
    nbusy = 0;
    while (done !== 1'b1 && lat < 60) begin
      if (busy === 1'b1) nbusy++;
      start = extra && (lat == 5 || lat == 12);
      bcd_in = extra ? rand_bcd() : bcd_in;
      @(posedge CLK);
      #2;
      lat++;
    end
    start = 1'b0;
  endtask

  initial begin
    int lat;
    int nb;
    int dc0;

    reset_n = 1'b0;
    repeat (2) @(posedge CLK);
    run_chk = 1'b1;
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_bin", 32'(bin_out), 32'd0);
    @(posedge CLK);
    #2;
    reset_n = 1'b1;

    // Pin the reference model with hand-computed values.
    check("ref_999999", 32'(ref_val(24'h999999, 1'b0)), 32'hF423F);
    check("ref_012345", 32'(ref_val(24'h012345, 1'b0)), 32'h03039);
    check("ref_bad_A", 32'(ref_bad(24'h00A100)), 32'd1);
    check("ref_42", 32'(ref_val(24'h000042, 1'b0)), 32'd42);
    check("ref_neg123", 32'(ref_val(24'h000123, 1'b1)), 32'hFFF85);

    repeat (2) @(posedge CLK);
    #2;

    // Zero input.
    run_conv(24'h000000, 1'b0, 1'b0, lat, nb);
    check("t1_lat", 32'(lat), 32'd24);
    check("t1_bin", 32'(bin_out), 32'd0);
    check("t1_err", 32'(err), 32'd0);

    // Largest input, accepted straight from DONE.
    run_conv(24'h999999, 1'b0, 1'b0, lat, nb);
    check("t2_lat", 32'(lat), 32'd24);
    check("t2_busy_cycles", 32'(nb), 32'd24);
    check("t2_bin", 32'(bin_out), 32'hF423F);

    // Extra starts and bcd_in changes while busy are ignored.
    @(posedge CLK);
    #2;
    dc0 = done_cnt;
    run_conv(24'h012345, 1'b0, 1'b1, lat, nb);
    check("t3_lat", 32'(lat), 32'd24);
    check("t3_bin", 32'(bin_out), 32'h03039);
    repeat (3) @(posedge CLK);
    #2;
    check("t3_done_pulses", 32'(done_cnt - dc0), 32'd1);

    // Bad digit: immediate done with err, then a good request clears err.
    run_conv(24'h00A100, 1'b0, 1'b0, lat, nb);
    check("t4_lat", 32'(lat), 32'd0);
    check("t4_err", 32'(err), 32'd1);
    check("t4_bin", 32'(bin_out), 32'd0);
    @(posedge CLK);
    #2;
    check("t4_done_drop", 32'(done), 32'd0);
    run_conv(24'h000042, 1'b0, 1'b0, lat, nb);
    check("t4b_bin", 32'(bin_out), 32'd42);
    check("t4b_err", 32'(err), 32'd0);

    // Reset mid-conversion aborts with no done pulse.
    bcd_in = 24'h000777;
    start  = 1'b1;
    @(posedge CLK);
    #2;
    start = 1'b0;
    repeat (10) @(posedge CLK);
    #2;
    dc0 = done_cnt;
    reset_n = 1'b0;
    #1;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_bin", 32'(bin_out), 32'd0);
    repeat (3) @(posedge CLK);
    #2;
    reset_n = 1'b1;
    repeat (30) @(posedge CLK);
    #2;
    check("t5_no_done", 32'(done_cnt - dc0), 32'd0);
    run_conv(24'h000777, 1'b0, 1'b0, lat, nb);
    check("t5b_lat", 32'(lat), 32'd24);
    check("t5b_bin", 32'(bin_out), 32'd777);

`ifdef BCD2BIN_SIGN_EN
    // Signed results.
    run_conv(24'h000123, 1'b1, 1'b0, lat, nb);
    check("t6_neg123", 32'(bin_out), 32'hFFF85);
    run_conv(24'h000000, 1'b1, 1'b0, lat, nb);
    check("t6_negzero", 32'(bin_out), 32'd0);
`endif

    // Randomized traffic, including back-to-back starts and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      @(posedge CLK);
      #2;
      reset_n = ($urandom_range(0, 399) != 0);
      start   = ($urandom_range(0, 3) == 0);
      bcd_in  = rand_bcd();
      neg_in  = 1'($urandom_range(0, 1));
    end
    @(posedge CLK);
    #2;
    reset_n = 1'b1;
    start   = 1'b0;
    repeat (30) @(posedge CLK);
    #2;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
